external_bus_responder: RTL and testbench

- Bus-side counterpart of the cpu external bus: services the cpu's read/write requests from a word-addressed internal RAM and returns data with a fixed, configurable read latency.
- Also generates the level interrupt request into the cpu and clears it on the cpu's grant.
- Sits outside the cpu and replaces bench-driven instruction/data stimulus.

---
 rtl/external_bus_responder.sv | 155 +++++++++++++++
 tb/tb_external_bus_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/external_bus_responder.sv
// Bus-side responder for the cpu external bus: word-addressed RAM with byte lanes,
// fixed read latency, one-cycle ready/error pulses, and a level interrupt request.
module external_bus_responder #(
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk_from_external,
    input  logic        reset_from_external,
    input  logic [31:0] address_to_external_bus_from_cpu,
    input  logic [31:0] outputdata_to_external_bus,
    input  logic [3:0]  control_output_to_external_bus,
    output logic [31:0] inputdata_from_external_bus,
    output logic        bus_ready_to_cpu,
    output logic        bus_error_to_cpu,
    input  logic        irq_source_pulse,
    output logic        interrupt_from_external,
    input  logic        interrupt_grant_from_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   idx_q;
    logic            err_q;
    logic [31:0]     mem [DEPTH];

    logic            req;
    logic            wr;
    logic [1:0]      size;
    logic [AW-1:0]   idx;
    logic            req_err;
    logic [3:0]      be;
    logic [31:0]     wdata_lanes;

    assign req  = control_output_to_external_bus[3];
    assign wr   = control_output_to_external_bus[2];
    assign size = control_output_to_external_bus[1:0];
    assign idx  = address_to_external_bus_from_cpu[AW+1:2];

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        req_err     = 1'b0;
        be          = 4'b0000;
        wdata_lanes = outputdata_to_external_bus;
        case (size)
            2'b00: begin
                be[address_to_external_bus_from_cpu[1:0]] = 1'b1;
                wdata_lanes = {4{outputdata_to_external_bus[7:0]}};
            end
            2'b01: begin
                req_err     = address_to_external_bus_from_cpu[0];
                be          = address_to_external_bus_from_cpu[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{outputdata_to_external_bus[15:0]}};
            end
            2'b10: begin
                req_err = |address_to_external_bus_from_cpu[1:0];
                be      = 4'b1111;
            end
            default: req_err = 1'b1;
        endcase
        // Addresses beyond the RAM would otherwise alias onto low words.
        if (|address_to_external_bus_from_cpu[31:AW+2]) begin
            req_err = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk_from_external) begin
        if (reset_from_external) begin
            state                       <= ST_IDLE;
            cnt                         <= '0;
            idx_q                       <= '0;
            err_q                       <= 1'b0;
            bus_ready_to_cpu            <= 1'b0;
            bus_error_to_cpu            <= 1'b0;
            inputdata_from_external_bus <= 32'h0;
        end else begin
            bus_ready_to_cpu <= 1'b0;
            bus_error_to_cpu <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        idx_q <= idx;
                        err_q <= req_err;
                        if (wr) begin
                            state            <= ST_RESP;
                            bus_ready_to_cpu <= 1'b1;
                            bus_error_to_cpu <= req_err;
                            if (req_err) begin
                                inputdata_from_external_bus <= 32'h0;
                            end
                        end else if (READ_LATENCY == 1) begin
                            state                       <= ST_RESP;
                            bus_ready_to_cpu            <= 1'b1;
                            bus_error_to_cpu            <= req_err;
                            inputdata_from_external_bus <= req_err ? 32'h0 : mem[idx];
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CW'(READ_LATENCY - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    // The decrement that reaches zero is the edge that enters RESP.
                    if (cnt <= CW'(1)) begin
                        cnt                         <= '0;
                        state                       <= ST_RESP;
                        bus_ready_to_cpu            <= 1'b1;
                        bus_error_to_cpu            <= err_q;
                        inputdata_from_external_bus <= err_q ? 32'h0 : mem[idx_q];
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: the RAM has no reset; only the write strobe is gated so an abandoned request never lands.
    always_ff @(posedge clk_from_external) begin
        if (!reset_from_external && state == ST_IDLE && req && wr && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][i*8 +: 8] <= wdata_lanes[i*8 +: 8];
                end
            end
        end
    end

    // A pulse in the same cycle as a grant wins, so the request re-asserts.
    always_ff @(posedge clk_from_external) begin
        if (reset_from_external) begin
            interrupt_from_external <= 1'b0;
        end else if (irq_source_pulse) begin
            interrupt_from_external <= 1'b1;
        end else if (interrupt_grant_from_pc) begin
            interrupt_from_external <= 1'b0;
        end
    end

endmodule

// File: tb/tb_external_bus_responder.sv
// Scoreboard bench for external_bus_responder: expected responses are queued at issue
// and compared, including arrival cycle, when the ready pulse appears.
module tb_external_bus_responder;

    localparam int DEPTH = 256;
    localparam int RL    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ctrl;
    logic [31:0] rdata;
    logic        ready;
    logic        berr;
    logic        pulse;
    logic        irq;
    logic        grant;

    always #5 clk = ~clk;

    external_bus_responder #(
        .DEPTH       (DEPTH),
        .READ_LATENCY(RL)
    ) dut (
        .clk_from_external               (clk),
        .reset_from_external             (rst),
        .address_to_external_bus_from_cpu(addr),
        .outputdata_to_external_bus      (wdata),
        .control_output_to_external_bus  (ctrl),
        .inputdata_from_external_bus     (rdata),
        .bus_ready_to_cpu                (ready),
        .bus_error_to_cpu                (berr),
        .irq_source_pulse                (pulse),
        .interrupt_from_external         (irq),
        .interrupt_grant_from_pc         (grant)
    );

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
        logic        chk;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_ready", 32'(ready), 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("ready_cycle", cyc, e.cyc);
                check("error_flag", 32'(berr), 32'(e.err));
                if (e.chk) check("read_data", rdata, e.data);
            end
        end else if (berr !== 1'b0) begin
            check("error_without_ready", 32'(berr), 32'h0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [31:0] d, input logic e, input logic chk);
        exp_t x;
        x.cyc  = c;
        x.data = d;
        x.err  = e;
        x.chk  = chk;
        exp_q.push_back(x);
    endtask

    task automatic drain;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            check("response_timeout", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
        end
    endtask

    // One request held for its accept cycle only; returns in the first IDLE cycle after ready.
    task automatic xact(input logic [31:0] a, input logic [1:0] sz, input logic w,
                        input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e);
        addr  = a;
        wdata = d;
        ctrl  = {1'b1, w, sz};
        push(cyc + (w ? 1 : RL), exp_d, exp_e, !w || exp_e);
        tick();
        ctrl = 4'h0;
        drain();
    endtask

    task automatic irq_step(input logic p, input logic g, input logic exp_irq, input string tag);
        pulse = p;
        grant = g;
        tick();
        pulse = 1'b0;
        grant = 1'b0;
        @(negedge clk);
        check(tag, 32'(irq), 32'(exp_irq));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int t;
        rst   = 1'b1;
        addr  = 32'h0;
        wdata = 32'h0;
        ctrl  = 4'h0;
        pulse = 1'b0;
        grant = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_rdata", rdata, 32'h0);
        check("reset_ready", 32'(ready), 32'h0);
        check("reset_error", 32'(berr), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        rst = 1'b0;
        tick();

        // Basic word write and read-back.
        xact(32'h10, 2'b10, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0);
        xact(32'h10, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);

        // Byte and half lanes; reads return the whole word regardless of size/offset.
        xact(32'h11, 2'b00, 1'b1, 32'hFFFF_FFA5, 32'h0, 1'b0);
        xact(32'h12, 2'b01, 1'b1, 32'hFFFF_1234, 32'h0, 1'b0);
        xact(32'h10, 2'b10, 1'b0, 32'h0, 32'h1234A5EF, 1'b0);
        xact(32'h13, 2'b00, 1'b0, 32'h0, 32'h1234A5EF, 1'b0);
        xact(32'h20, 2'b10, 1'b1, 32'h0BAD_F00D, 32'h0, 1'b0);
        xact(32'h22, 2'b01, 1'b0, 32'h0, 32'h0BADF00D, 1'b0);

        // Error cases: ready+error together, data 0, nothing written.
        xact(32'h13, 2'b01, 1'b1, 32'h0000_5555, 32'h0, 1'b1);
        xact(32'h06, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
        xact(32'h10, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
        xact(32'h10, 2'b11, 1'b1, 32'h7777_7777, 32'h0, 1'b1);
        xact(32'h12, 2'b10, 1'b1, 32'h6666_6666, 32'h0, 1'b1);
        xact(4 * DEPTH, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
        xact(4 * DEPTH + 32'h10, 2'b10, 1'b1, 32'h1111_1111, 32'h0, 1'b1);
        xact(32'h10, 2'b10, 1'b0, 32'h0, 32'h1234A5EF, 1'b0);

        // Request held for three transactions: one ready each, accept only in IDLE.
        addr = 32'h10;
        ctrl = 4'b1010;
        t    = cyc;
        push(t + 2, 32'h1234A5EF, 1'b0, 1'b1);
        push(t + 5, 32'h1234A5EF, 1'b0, 1'b1);
        push(t + 8, 32'h1234A5EF, 1'b0, 1'b1);
        repeat (9) tick();
        ctrl = 4'h0;
        drain();
        repeat (4) tick();

        // A write that arrives while a read is in WAIT waits for IDLE.
        addr = 32'h10;
        ctrl = 4'b1010;
        t    = cyc;
        push(t + 2, 32'h1234A5EF, 1'b0, 1'b1);
        tick();
        addr  = 32'h30;
        wdata = 32'hCAFE_F00D;
        ctrl  = 4'b1110;
        push(t + 4, 32'h0, 1'b0, 1'b0);
        repeat (3) tick();
        ctrl = 4'h0;
        drain();
        xact(32'h30, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);

        // Interrupt request: set, merge, grant, set-wins-over-grant.
        irq_step(1'b0, 1'b0, 1'b0, "irq_idle");
        irq_step(1'b1, 1'b0, 1'b1, "irq_set");
        irq_step(1'b1, 1'b0, 1'b1, "irq_merge");
        irq_step(1'b0, 1'b0, 1'b1, "irq_hold");
        irq_step(1'b0, 1'b0, 1'b1, "irq_hold2");
        irq_step(1'b0, 1'b1, 1'b0, "irq_grant_clear");
        irq_step(1'b0, 1'b0, 1'b0, "irq_stays_clear");
        irq_step(1'b1, 1'b0, 1'b1, "irq_reset_again");
        irq_step(1'b1, 1'b1, 1'b1, "irq_set_wins");
        irq_step(1'b0, 1'b1, 1'b0, "irq_second_grant");
        irq_step(1'b1, 1'b0, 1'b1, "irq_pending_before_reset");

        // Reset during the WAIT of a read: no ready, outputs cleared.
        tick();
        addr = 32'h10;
        ctrl = 4'b1010;
        tick();
        ctrl = 4'h0;
        rst  = 1'b1;
        tick();
        @(negedge clk);
        check("rst_wait_ready", 32'(ready), 32'h0);
        check("rst_wait_rdata", rdata, 32'h0);
        check("rst_wait_irq", 32'(irq), 32'h0);
        rst = 1'b0;
        repeat (4) tick();

        // Reset coinciding with a write request: write never lands.
        addr  = 32'h10;
        wdata = 32'hFFFF_FFFF;
        ctrl  = 4'b1110;
        rst   = 1'b1;
        tick();
        ctrl = 4'h0;
        rst  = 1'b0;
        @(negedge clk);
        check("rst_write_ready", 32'(ready), 32'h0);
        repeat (4) tick();
        xact(32'h10, 2'b10, 1'b0, 32'h0, 32'h1234A5EF, 1'b0);
        xact(32'h30, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
